// File: rtl/cbt_align_pkg.sv
// Shared constants, FSM state encoding and idle-pattern helper for the CBT receive lane aligner.
package cbt_align_pkg;

    localparam int kDevW        = 8;
    localparam logic [kDevW-1:0] kPattern = 8'b1111_0000;
    localparam int kInitWait    = 64;
    localparam int kSettle      = 16;
    localparam int kCheckCycles = 256;
    localparam int kMinWindow   = 4;

    localparam int kTapNum = 32;
    localparam int kTapW   = $clog2(kTapNum);
    localparam int kLenW   = $clog2(kTapNum + 1);
    localparam int kSlipW  = $clog2(kDevW);

    // One counter serves init wait, settle and check; sized for the longest of the three.
    localparam int kCntMax = (kCheckCycles > kInitWait)
                           ? ((kCheckCycles > kSettle) ? kCheckCycles : kSettle)
                           : ((kInitWait > kSettle) ? kInitWait : kSettle);
    localparam int kCntW   = $clog2(kCntMax);

    typedef enum logic [3:0] {
        S_WAIT,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_NEXT,
        S_CALC,
        S_LOAD_BEST,
        S_SLIP_SETTLE,
        S_SLIP_CHECK,
        S_SLIP,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic logic is_pattern_rotation(input logic [kDevW-1:0] word);
        logic [kDevW-1:0] rot;
        logic             hit;
        rot = kPattern;
        hit = 1'b0;
        for (int i = 0; i < kDevW; i++) begin
            if (word == rot) hit = 1'b1;
            rot = {rot[kDevW-2:0], rot[kDevW-1]};
        end
        return hit;
    endfunction

endpackage

// File: rtl/cbt_rx_lane_aligner_if.sv
// Lane control and link status bundle of the aligner; debug taps present only with CBT_ALIGN_DEBUG_EN.
interface cbt_rx_lane_aligner_if;
    import cbt_align_pkg::*;

    logic                 restart;
    logic [kDevW-1:0]     dInFromLane;
    logic [kTapW-1:0]     tapIn;
    logic                 rstIDelay;
    logic                 enVtc;
    logic                 bitslip;
    logic                 initDone;
    logic                 initError;
    logic [kTapW-1:0]     bestTap;
`ifdef CBT_ALIGN_DEBUG_EN
    logic [kTapNum-1:0]   passMap;
    logic [kLenW-1:0]     windowLen;

    modport master (input restart, dInFromLane,
                    output tapIn, rstIDelay, enVtc, bitslip, initDone, initError, bestTap,
                    output passMap, windowLen);
    modport slave  (output restart, dInFromLane,
                    input tapIn, rstIDelay, enVtc, bitslip, initDone, initError, bestTap,
                    input passMap, windowLen);
`else
    modport master (input restart, dInFromLane,
                    output tapIn, rstIDelay, enVtc, bitslip, initDone, initError, bestTap);
    modport slave  (output restart, dInFromLane,
                    input tapIn, rstIDelay, enVtc, bitslip, initDone, initError, bestTap);
`endif

endinterface

// File: rtl/cbt_tap_window.sv
// Serial longest-run finder over the tap pass map: one bit per cycle, valid pulses after the last tap.
module cbt_tap_window
    import cbt_align_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [kTapNum-1:0] pass_map,
    output logic               valid,
    output logic [kTapW-1:0]   centre,
    output logic [kLenW-1:0]   len
);

    logic               busy;
    logic [kTapW-1:0]   idx;
    logic [kLenW-1:0]   run_len;
    logic [kTapW-1:0]   run_start;
    logic [kLenW-1:0]   best_len;
    logic [kTapW-1:0]   best_start;
    logic [kLenW-1:0]   ext_len;
    logic [kTapW-1:0]   ext_start;
    logic [kLenW-1:0]   half;

    always_comb begin
        ext_len   = run_len + 1'b1;
        ext_start = (run_len == '0) ? idx : run_start;
        half      = (best_len == '0) ? '0 : ((best_len - 1'b1) >> 1);
    end

    // Strictly-greater update keeps the earliest run on equal lengths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            valid      <= 1'b0;
            idx        <= '0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                busy       <= 1'b1;
                idx        <= '0;
                run_len    <= '0;
                run_start  <= '0;
                best_len   <= '0;
                best_start <= '0;
            end else if (busy) begin
                if (pass_map[idx]) begin
                    run_len   <= ext_len;
                    run_start <= ext_start;
                    if (ext_len > best_len) begin
                        best_len   <= ext_len;
                        best_start <= ext_start;
                    end
                end else begin
                    run_len <= '0;
                end
                if (idx == kTapW'(kTapNum - 1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign len    = best_len;
    assign centre = best_start + half[kTapW-1:0];

endmodule

// File: rtl/cbt_rx_lane_aligner.sv
// Tap scan, eye centring and bitslip word alignment for the CDCM 8:1 receive lane.
// Optional debug outputs (passMap, windowLen) are enabled with CBT_ALIGN_DEBUG_EN.
module cbt_rx_lane_aligner
    import cbt_align_pkg::*;
(
    input  logic                          clkDivIn,
    input  logic                          ioResetN,
    cbt_rx_lane_aligner_if.master         align
);

    state_t              state, state_d;
    logic [kCntW-1:0]    cnt, cnt_d;
    logic [kTapW-1:0]    tap, tap_d;
    logic [kTapW-1:0]    best, best_d;
    logic [kSlipW-1:0]   slip_cnt, slip_cnt_d;
    logic [kDevW-1:0]    ref_word, ref_word_d;
    logic                tap_pass, tap_pass_d;
    logic [kTapNum-1:0]  pass_map, pass_map_d;

    logic                win_start;
    logic                win_valid;
    logic [kTapW-1:0]    win_centre;
    logic [kLenW-1:0]    win_len;

    cbt_tap_window u_window (
        .clk      (clkDivIn),
        .rst_n    (ioResetN),
        .start    (win_start),
        .pass_map (pass_map),
        .valid    (win_valid),
        .centre   (win_centre),
        .len      (win_len)
    );

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    // NOTE: pass_map is a flop vector rather than RAM, so it can take the asynchronous reset.
    always_ff @(posedge clkDivIn or negedge ioResetN) begin
        if (!ioResetN) begin
            state    <= S_WAIT;
            cnt      <= '0;
            tap      <= '0;
            best     <= '0;
            slip_cnt <= '0;
            ref_word <= '0;
            tap_pass <= 1'b0;
            pass_map <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            tap      <= tap_d;
            best     <= best_d;
            slip_cnt <= slip_cnt_d;
            ref_word <= ref_word_d;
            tap_pass <= tap_pass_d;
            pass_map <= pass_map_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        tap_d      = tap;
        best_d     = best;
        slip_cnt_d = slip_cnt;
        ref_word_d = ref_word;
        tap_pass_d = tap_pass;
        pass_map_d = pass_map;
        win_start  = 1'b0;

        unique case (state)
            S_WAIT: begin
                if (cnt == kCntW'(kInitWait - 1)) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    tap_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE, S_SLIP_SETTLE: begin
                if (cnt == kCntW'(kSettle - 1)) begin
                    state_d = (state == S_SETTLE) ? S_CHECK : S_SLIP_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_CHECK: begin
                cnt_d = cnt + 1'b1;
                if (cnt == '0) begin
                    ref_word_d = align.dInFromLane;
                    if (!is_pattern_rotation(align.dInFromLane)) begin
                        tap_pass_d = 1'b0;
                        state_d    = S_NEXT;
                        cnt_d      = '0;
                    end
                end else if (align.dInFromLane != ref_word) begin
                    tap_pass_d = 1'b0;
                    state_d    = S_NEXT;
                    cnt_d      = '0;
                end else if (cnt == kCntW'(kCheckCycles - 1)) begin
                    tap_pass_d = 1'b1;
                    state_d    = S_NEXT;
                    cnt_d      = '0;
                end
            end
            S_NEXT: begin
                pass_map_d[tap] = tap_pass;
                if (tap == kTapW'(kTapNum - 1)) begin
                    state_d   = S_CALC;
                    win_start = 1'b1;
                end else begin
                    tap_d   = tap + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_CALC: begin
                if (win_valid) begin
                    if (win_len >= kLenW'(kMinWindow)) begin
                        state_d    = S_LOAD_BEST;
                        tap_d      = win_centre;
                        best_d     = win_centre;
                        slip_cnt_d = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LOAD_BEST: begin
                state_d = S_SLIP_SETTLE;
                cnt_d   = '0;
            end
            S_SLIP_CHECK: begin
                if (align.dInFromLane == kPattern) begin
                    state_d = S_DONE;
                end else if (slip_cnt == kSlipW'(kDevW - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_SLIP;
                end
            end
            S_SLIP: begin
                slip_cnt_d = slip_cnt + 1'b1;
                state_d    = S_SLIP_SETTLE;
                cnt_d      = '0;
            end
            S_DONE, S_ERROR: begin
                if (align.restart) begin
                    state_d    = S_WAIT;
                    cnt_d      = '0;
                    slip_cnt_d = '0;
                    tap_pass_d = 1'b0;
                    pass_map_d = '0;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Strobes and flags decode straight from state, so reset forces them to idle at once.
    assign align.tapIn     = tap;
    assign align.bestTap   = best;
    assign align.rstIDelay = (state == S_LOAD) || (state == S_LOAD_BEST);
    assign align.bitslip   = (state == S_SLIP);
    assign align.enVtc     = state inside {S_WAIT, S_DONE, S_ERROR};
    assign align.initDone  = (state == S_DONE);
    assign align.initError = (state == S_ERROR);
`ifdef CBT_ALIGN_DEBUG_EN
    assign align.passMap   = pass_map;
    assign align.windowLen = win_len;
`endif

endmodule

// File: tb/tb_cbt_rx_lane_aligner.sv
// Directed and randomized alignment runs against a behavioural lane model and window reference.
module tb_cbt_rx_lane_aligner;
    import cbt_align_pkg::*;

    localparam int kBudget = 20000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cbt_rx_lane_aligner_if bus ();

    cbt_rx_lane_aligner dut (
        .clkDivIn (clk),
        .ioResetN (rst_n),
        .align    (bus)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Lane scenario (written by the main sequence only).
    logic [31:0] good_mask  = 32'h0;
    bit          aa_mode    = 1'b0;
    int          lane_rot   = 0;

    // Lane state and observations (written by the lane process only).
    int lane_tap   = 0;
    int lane_slips = 0;
    int violations = 0;
    int load_log[$];

    function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
        logic [15:0] two;
        two = {w, w} << (r % 8);
        return two[15:8];
    endfunction

    function automatic logic [31:0] run_mask(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] lane_word();
        if (aa_mode) return 8'hAA;
        if (good_mask[lane_tap]) return rotl(kPattern, lane_rot + lane_slips);
        return 8'($urandom);
    endfunction

    // Lane model: latches the tap on LOAD, rotates one bit per bitslip, noisy outside the eye.
    initial begin
        bus.dInFromLane = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rstIDelay) begin
                lane_tap = int'(bus.tapIn);
                load_log.push_back(int'(bus.tapIn));
            end
            if (bus.bitslip) lane_slips++;
            if ((bus.rstIDelay && bus.bitslip) ||
                ((bus.rstIDelay || bus.bitslip) && bus.enVtc) ||
                (bus.initDone && bus.initError))
                violations++;
            bus.dInFromLane = lane_word();
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Widest all-pass span, lowest start on ties, centre rounded down.
    task automatic model_window(input logic [31:0] mask, output int len, output int centre);
        bit all;
        len    = 0;
        centre = 0;
        for (int s = 0; s < 32; s++) begin
            for (int e = s; e < 32; e++) begin
                all = 1'b1;
                for (int k = s; k <= e; k++) if (!mask[k]) all = 1'b0;
                if (all && (e - s + 1) > len) begin
                    len    = e - s + 1;
                    centre = s + (len - 1) / 2;
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " tapIn"},     32'(bus.tapIn),     0);
        check({tag, " rstIDelay"}, 32'(bus.rstIDelay), 0);
        check({tag, " enVtc"},     32'(bus.enVtc),     1);
        check({tag, " bitslip"},   32'(bus.bitslip),   0);
        check({tag, " initDone"},  32'(bus.initDone),  0);
        check({tag, " initError"}, 32'(bus.initError), 0);
        check({tag, " bestTap"},   32'(bus.bestTap),   0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(bus.initDone || bus.initError) && n < kBudget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " finished"}, 32'(n < kBudget), 1);
    endtask

    task automatic wait_load(input string tag, input int tap, input int load_snap);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < kBudget) begin
            @(negedge clk);
            n++;
            if (load_log.size() > load_snap && load_log[load_log.size() - 1] == tap) seen = 1'b1;
        end
        check({tag, " reached tap"}, 32'(seen), 1);
    endtask

    task automatic pulse_restart(input string tag);
        @(negedge clk);
        bus.restart = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " done dropped"},  32'(bus.initDone),  0);
        check({tag, " error dropped"}, 32'(bus.initError), 0);
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic expect_outcome(input string tag, input int load_snap, input int slip_snap,
                                  input int viol_snap);
        logic [31:0] map;
        int          len, centre, exp_pulses, n_loads;
        bit          win_ok, seq_ok;
        map = aa_mode ? 32'h0 : good_mask;
        model_window(map, len, centre);
        win_ok     = (len >= kMinWindow);
        exp_pulses = win_ok ? (8 - ((lane_rot + slip_snap) % 8)) % 8 : 0;
        wait_done(tag);
        check({tag, " initDone"},  32'(bus.initDone),  32'(win_ok));
        check({tag, " initError"}, 32'(bus.initError), 32'(!win_ok));
        check({tag, " enVtc"},     32'(bus.enVtc),     1);
        if (win_ok) check({tag, " bestTap"}, 32'(bus.bestTap), centre);
        check({tag, " bitslips"}, lane_slips - slip_snap, exp_pulses);
        n_loads = load_log.size() - load_snap;
        check({tag, " loads"}, n_loads, win_ok ? 33 : 32);
        seq_ok = 1'b1;
        for (int i = 0; i < 32 && i < n_loads; i++)
            if (load_log[load_snap + i] != i) seq_ok = 1'b0;
        if (win_ok && n_loads >= 33 && load_log[load_snap + 32] != centre) seq_ok = 1'b0;
        check({tag, " tap order"}, 32'(seq_ok), 1);
        check({tag, " strobe rules"}, violations - viol_snap, 0);
`ifdef CBT_ALIGN_DEBUG_EN
        check({tag, " passMap"},   bus.passMap,        map);
        check({tag, " windowLen"}, 32'(bus.windowLen), len);
`endif
    endtask

    task automatic restart_run(input string tag, input logic [31:0] mask, input bit aa,
                               input int rot);
        int ls, ss, vs;
        good_mask = mask;
        aa_mode   = aa;
        lane_rot  = rot;
        ls = load_log.size();
        ss = lane_slips;
        vs = violations;
        pulse_restart(tag);
        expect_outcome(tag, ls, ss, vs);
    endtask

    initial begin
        int ls, ss, vs, s, l, a0, a1, b0, b1;
        bus.restart = 1'b0;
        good_mask   = run_mask(10, 20);
        aa_mode     = 1'b0;
        lane_rot    = 3;

        #12;
        @(negedge clk);
        check_reset_values("reset");

        ls = load_log.size();
        ss = lane_slips;
        vs = violations;
        rst_n = 1'b1;
        expect_outcome("eye10_20", ls, ss, vs);

        restart_run("two_runs", run_mask(2, 4) | run_mask(20, 29), 1'b0, int'($urandom_range(0, 7)));
        restart_run("narrow",   run_mask(5, 7), 1'b0, int'($urandom_range(0, 7)));
        restart_run("aa_word",  32'hFFFF_FFFF, 1'b1, 0);

        // Asynchronous reset while tap 12 is being checked, then a clean rescan.
        good_mask = run_mask(10, 20);
        aa_mode   = 1'b0;
        lane_rot  = int'($urandom_range(0, 7));
        ls = load_log.size();
        pulse_restart("mid_reset");
        wait_load("mid_reset", 12, ls);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (3) @(negedge clk);
        ls = load_log.size();
        ss = lane_slips;
        vs = violations;
        rst_n = 1'b1;
        expect_outcome("after_reset", ls, ss, vs);

        // restart pulse while a good tap is being checked must be ignored.
        s = int'($urandom_range(0, 16));
        l = int'($urandom_range(4, 12));
        good_mask = run_mask(s, s + l - 1);
        lane_rot  = int'($urandom_range(0, 7));
        ls = load_log.size();
        ss = lane_slips;
        vs = violations;
        pulse_restart("busy_restart");
        wait_load("busy_restart", s, ls);
        repeat (30) @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        expect_outcome("busy_restart", ls, ss, vs);

        for (int r = 0; r < 2; r++) begin
            a0 = int'($urandom_range(0, 14));
            a1 = a0 + int'($urandom_range(0, 7));
            b0 = int'($urandom_range(12, 26));
            b1 = b0 + int'($urandom_range(0, 5));
            restart_run($sformatf("random%0d", r), run_mask(a0, a1) | run_mask(b0, b1), 1'b0,
                        int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
